// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-file widths and writeback source encoding
package regfile_wb_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;
  typedef enum logic {WB_SRC_ALU, WB_SRC_MEM} wb_src_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requesters, issue-stage query and register-bank write port
interface regfile_wb_arbiter_if import regfile_wb_arbiter_pkg::*; ;
  logic              alu_wb_valid;
  logic              alu_wb_ready;
  logic [ADDR_W-1:0] alu_wb_addr;
  logic [DATA_W-1:0] alu_wb_data;
  logic              mem_wb_valid;
  logic              mem_wb_ready;
  logic [ADDR_W-1:0] mem_wb_addr;
  logic [DATA_W-1:0] mem_wb_data;
  logic              issue_valid;
  logic              issue_rd_we;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic              issue_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_error;
  modport master (
    output alu_wb_valid, alu_wb_addr, alu_wb_data, mem_wb_valid, mem_wb_addr, mem_wb_data,
           issue_valid, issue_rd_we, issue_rd, issue_rs1, issue_rs2,
    input  alu_wb_ready, mem_wb_ready, issue_stall, rf_we, rf_waddr, rf_wdata, wb_error
  );
  modport slave (
    input  alu_wb_valid, alu_wb_addr, alu_wb_data, mem_wb_valid, mem_wb_addr, mem_wb_data,
           issue_valid, issue_rd_we, issue_rd, issue_rs1, issue_rs2,
    output alu_wb_ready, mem_wb_ready, issue_stall, rf_we, rf_waddr, rf_wdata, wb_error
  );
endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// wb_scoreboard: per-register pending-write bits with set-wins and hardwired-zero r0
module wb_scoreboard import regfile_wb_arbiter_pkg::*; (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              rd_busy_o,
  output logic              clr_err_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;
  // a clear applied after masking with set lets a same-register set win
  always_comb begin
    set_mask = (set_en_i && set_addr_i != '0) ? NUM_REGS'(1) << set_addr_i : '0;
    clr_mask = (clr_en_i && clr_addr_i != '0) ? NUM_REGS'(1) << clr_addr_i : '0;
    busy_d = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end
  // pending-write vector
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) busy_q <= '0;
    else busy_q <= busy_d;
  assign rs1_busy_o = busy_q[rs1_i];
  assign rs2_busy_o = busy_q[rs2_i];
  assign rd_busy_o = busy_q[rd_i];
  assign clr_err_o = clr_en_i && clr_addr_i != '0 && !busy_q[clr_addr_i];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU/load writebacks onto the register bank write port with hazard scoreboard
module regfile_wb_arbiter import regfile_wb_arbiter_pkg::*; #(
  parameter int STARVE_LIMIT = 3
) (
  input logic                 clock,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  wb_src_t           src;
  logic              alu_hs, mem_hs, hs, stall, rs1_busy, rs2_busy, rd_busy, clr_err;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        starve_q, starve_d;
  logic              rf_we_q, rf_we_d, wb_error_q, wb_error_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  // loads win by default; a starved ALU takes the port once the limit is reached
  always_comb begin
    src = (bus.alu_wb_valid && (!bus.mem_wb_valid || starve_q == 4'(STARVE_LIMIT))) ? WB_SRC_ALU : WB_SRC_MEM;
    alu_hs = bus.alu_wb_valid && src == WB_SRC_ALU;
    mem_hs = bus.mem_wb_valid && src == WB_SRC_MEM;
    hs = alu_hs || mem_hs;
    wb_addr = src == WB_SRC_ALU ? bus.alu_wb_addr : bus.mem_wb_addr;
    wb_data = src == WB_SRC_ALU ? bus.alu_wb_data : bus.mem_wb_data;
    starve_d = (bus.alu_wb_valid && !alu_hs) ? (starve_q == 4'(STARVE_LIMIT) ? starve_q : starve_q + 4'd1) : '0;
    rf_we_d = hs && wb_addr != '0;
    rf_waddr_d = hs ? wb_addr : rf_waddr_q;
    rf_wdata_d = hs ? wb_data : rf_wdata_q;
    wb_error_d = wb_error_q || clr_err;
    stall = bus.issue_valid && (rs1_busy || rs2_busy || (bus.issue_rd_we && rd_busy));
  end
  // starvation counter, registered write port and sticky error
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      starve_q <= '0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_error_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_error_q <= wb_error_d;
    end
  wb_scoreboard u_sb (
    .clk_i(clock), .rst_i(reset),
    .set_en_i(bus.issue_valid && bus.issue_rd_we && !stall), .set_addr_i(bus.issue_rd),
    .clr_en_i(hs), .clr_addr_i(wb_addr),
    .rs1_i(bus.issue_rs1), .rs2_i(bus.issue_rs2), .rd_i(bus.issue_rd),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy), .rd_busy_o(rd_busy), .clr_err_o(clr_err)
  );
  assign bus.alu_wb_ready = alu_hs;
  assign bus.mem_wb_ready = mem_hs;
  assign bus.issue_stall = stall;
  assign bus.rf_we = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.wb_error = wb_error_q;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences the single write port of the 32x32 RV32I integer register bank.
- Arbitrates two writeback requesters, the ALU and the load unit, onto that port.
- Keeps a per-register pending-write scoreboard so the issue stage can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register bank's write_enable/write_addr/Wdata_in inputs.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)
STARVE_LIMIT, 3, consecutive ALU denials before ALU priority is forced (range 1..15)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
alu_wb_valid  in  1  ALU writeback request
alu_wb_ready  out  1  ALU request accepted this cycle
alu_wb_addr  in  ADDR_W  ALU destination register
alu_wb_data  in  DATA_W  ALU result
mem_wb_valid  in  1  load-unit writeback request
mem_wb_ready  out  1  load request accepted this cycle
mem_wb_addr  in  ADDR_W  load destination register
mem_wb_data  in  DATA_W  load data
issue_valid  in  1  issue stage presents an instruction
issue_rd_we  in  1  instruction writes rd
issue_rd  in  ADDR_W  instruction destination
issue_rs1  in  ADDR_W  source 1
issue_rs2  in  ADDR_W  source 2
issue_stall  out  1  instruction must not issue this cycle
rf_we  out  1  to register bank write_enable
rf_waddr  out  ADDR_W  to register bank write_addr
rf_wdata  out  DATA_W  to register bank Wdata_in
wb_error  out  1  sticky: writeback to a non-pending register

Behaviour:
- Reset (async, immediate):
  - busy[] = 0; rf_we = 0; rf_waddr = 0; rf_wdata = 0.
  - Starvation counter = 0; wb_error = 0.
  - An in-flight registered write is dropped.
- Arbitration (combinational ready):
  - Default priority is mem over alu.
  - If starve_cnt == STARVE_LIMIT and alu_wb_valid, alu wins.
  - Exactly one ready is high when any valid is high; none when neither is valid.
  - A handshake is valid & ready at the rising edge.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when alu_wb_valid && !alu_wb_ready.
  - Clears on an ALU handshake or when alu_wb_valid is low.
- Write stage:
  - Winner's addr/data are registered; rf_we rises the cycle after the handshake (latency 1).
  - Throughput is one write per cycle; back-to-back grants give consecutive rf_we pulses.
  - With no handshake, rf_we = 0 next cycle; rf_waddr/rf_wdata hold their last values.
- Address 0:
  - A handshake with addr 0 is accepted (ready asserted) but produces rf_we = 0 and has no scoreboard effect.
  - busy[0] is constantly 0.
- Scoreboard:
  - issue_stall = issue_valid && (busy[rs1] || busy[rs2] || (issue_rd_we && busy[rd])).
  - Reservation: issue_valid && issue_rd_we && !issue_stall && rd != 0 sets busy[rd] at the edge.
  - Clear: a writeback handshake to a nonzero addr clears busy[addr] at the same edge as the handshake, not at the rf_we cycle.
  - Stall is computed from registered busy only; no same-cycle clear bypass. Forwarding is handled elsewhere.
  - Simultaneous reserve and clear of the same register cannot occur legally, because reservation requires !busy.
  - If it does occur (clear of a non-busy register), set wins and wb_error is set.
  - wb_error also sets on any handshake to a nonzero register whose busy bit is 0.
  - wb_error is cleared only by reset.
- Valid inputs must hold stable until ready. The arbiter does not check this.

Decomposition:
- Shared package (core-wide use): ADDR_W, DATA_W, NUM_REGS, and a wb_src_t enum {WB_SRC_ALU, WB_SRC_MEM}.
- One sub-module: wb_scoreboard.
  - Holds the NUM_REGS busy vector.
  - Has set port (addr, en) and clear port (addr, en).
  - Has three combinational read ports for rs1/rs2/rd.
  - Implements the set-wins and r0 rules.
- The top module holds the arbitration, starvation counter and output register.

Test Plan:
- Reset mid-write:
  - Stimulus: mem handshake to x5 at cycle 3; assert reset at cycle 3.5.
  - Required: rf_we = 0 immediately; busy[5] = 0; wb_error = 0.
- Reserve, stall, writeback, release:
  - Stimulus: issue rd = x7; next cycle issue rs1 = x7; then alu writeback x7 = 0xDEADBEEF.
  - Required: issue_stall = 1 until the handshake edge, 0 the next cycle; rf_we = 1, rf_waddr = 7, rf_wdata = 0xDEADBEEF one cycle after the handshake.
- Simultaneous requests:
  - Stimulus: alu x3 = 0x11 and mem x4 = 0x22 both valid.
  - Required: mem granted first; alu granted the following cycle; rf_we pulses on two consecutive cycles with addr 4 then 3.
- Starvation:
  - Stimulus: mem_wb_valid held high continuously with alu_wb_valid high, STARVE_LIMIT = 3.
  - Required: alu denied 3 cycles, granted on the 4th cycle; counter then 0.
- r0 write:
  - Stimulus: alu writeback addr 0, data 0xFFFFFFFF.
  - Required: alu_wb_ready = 1, rf_we stays 0, busy unchanged, wb_error = 0.
- Unexpected writeback:
  - Stimulus: mem writeback to x9 with busy[9] = 0.
  - Required: write still performed (rf_we = 1, rf_waddr = 9); wb_error = 1 from the next cycle and stays high until reset.
